// File: rtl/aes_pkg.sv
// Shared AES definitions for the round-key generator.
//   - AES-128 round count, Rcon start value and reduction polynomial
//   - byte / word / 128-bit state typedefs and the schedule FSM state enum
//   - helpers that map the row-major 128-bit layout to and from column words
// Row-major layout: byte[r][c] = bits[127-32r-8c -: 8]; column c is word w_c,
// with row 0 in the most significant byte of the word.
package aes_pkg;

  localparam int        AES_NR    = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  typedef logic [7:0]       aes_byte_t;
  typedef logic [31:0]      aes_word_t;
  typedef logic [127:0]     aes_state_t;
  typedef logic [3:0][31:0] aes_cols_t;

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_EMIT = 1'b1
  } ks_state_e;

  // LSB position of byte[r][c] inside a row-major state.
  function automatic int byte_lsb(input int r, input int c);
    return 120 - 32 * r - 8 * c;
  endfunction

  // Gather column c of a row-major state into a word (row 0 in the MSB).
  function automatic aes_word_t state_col(input aes_state_t s, input int c);
    aes_word_t w;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      w[24 - 8 * r +: 8] = s[byte_lsb(r, c) +: 8];
    end
    return w;
  endfunction

  // Scatter four column words back into a row-major state.
  function automatic aes_state_t cols_to_state(input aes_cols_t cols);
    aes_state_t s;
    s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s[byte_lsb(r, c) +: 8] = cols[c][24 - 8 * r +: 8];
      end
    end
    return s;
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic aes_byte_t xtime(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Handshake bundle between the key loader, the key schedule and the
// AddRoundKey consumer.
//   key_in/key_valid/key_ready : cipher key load (loader -> schedule)
//   rk_out/rk_round/rk_valid/rk_ready : round-key stream (schedule -> consumer)
//   busy : schedule in progress
// modport slave is the key schedule itself; modport master is its environment.
interface aes_key_schedule_if;
  import aes_pkg::*;

  aes_state_t key_in;
  logic       key_valid;
  logic       key_ready;
  aes_state_t rk_out;
  logic [3:0] rk_round;
  logic       rk_valid;
  logic       rk_ready;
  logic       busy;

  modport master (
    output key_in, key_valid, rk_ready,
    input  key_ready, rk_out, rk_round, rk_valid, busy
  );

  modport slave (
    input  key_in, key_valid, rk_ready,
    output key_ready, rk_out, rk_round, rk_valid, busy
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
//   din  : input byte
//   dout : SubBytes(din)
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry 0 sits in the top byte, so entry d occupies bits [2047-8d -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // 2047 - 8*din == {~din, 3'b111}: the MSB index of entry din, exactly 11 bits wide.
  assign dout = SBOX_TBL[{~din, 3'b111} -: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 round-key generator.
// Accepts a 128-bit cipher key in IDLE, then streams round keys
// 0..NUM_ROUNDS, one per accepted valid/ready transfer.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   ks    : slave side of aes_key_schedule_if
//           key_in/key_valid/key_ready load the cipher key,
//           rk_out/rk_round/rk_valid/rk_ready carry the round keys,
//           busy is high while a schedule is being streamed.
// All 128-bit buses use the row-major layout described in aes_pkg.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_key_schedule_if.slave ks
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ks_state_e  state_q, state_d;
  aes_state_t rk_q, rk_d;
  logic [3:0] round_q, round_d;
  aes_byte_t  rcon_q, rcon_d;

  aes_cols_t  cols_cur;
  aes_cols_t  cols_nxt;
  aes_word_t  rot_word;
  aes_word_t  sub_word;
  aes_word_t  t_word;
  aes_state_t next_key;

  // Split the current round key into columns and build SubWord(RotWord(w3)).
  // RotWord maps byte order (r0,r1,r2,r3) to (r1,r2,r3,r0), so output byte
  // gi of the rotated word is row (gi+1)%4 of w3.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign cols_cur[gi] = state_col(rk_q, gi);
    assign rot_word[31 - 8 * gi -: 8] = cols_cur[3][31 - 8 * ((gi + 1) % 4) -: 8];

    aes_sbox u_sbox (
      .din  (rot_word[31 - 8 * gi -: 8]),
      .dout (sub_word[31 - 8 * gi -: 8])
    );
  end

  // Column XOR chain: each new column folds in the previously computed one.
  always_comb begin
    t_word      = sub_word ^ {rcon_q, 24'h000000};
    cols_nxt    = '0;
    cols_nxt[0] = cols_cur[0] ^ t_word;
    for (int c = 1; c < 4; c++) begin
      cols_nxt[c] = cols_cur[c] ^ cols_nxt[c - 1];
    end
    next_key = cols_to_state(cols_nxt);
  end

  // Next-state logic. The current round key is held in rk_q and only
  // advances on an accepted transfer, so it is stable across stalls.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    unique case (state_q)
      KS_IDLE: begin
        if (ks.key_valid) begin
          rk_d    = ks.key_in;
          round_d = 4'd0;
          rcon_d  = RCON_INIT;
          state_d = KS_EMIT;
        end
      end
      KS_EMIT: begin
        if (ks.rk_ready) begin
          if (round_q == LAST_ROUND) begin
            state_d = KS_IDLE;
          end else begin
            rk_d    = next_key;
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
          end
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KS_IDLE;
      rk_q    <= '0;
      round_q <= 4'd0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  // key_ready is low for the whole of EMIT, so a new key can only be taken
  // the cycle after the final round-key transfer.
  assign ks.key_ready = (state_q == KS_IDLE);
  assign ks.rk_valid  = (state_q == KS_EMIT);
  assign ks.busy      = (state_q != KS_IDLE);
  assign ks.rk_out    = rk_q;
  assign ks.rk_round  = round_q;

  ap_rk_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (ks.rk_valid && !ks.rk_ready) |=> $stable(ks.rk_out)
  );

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: scoreboard of expected round
// keys from an independent FIPS-197 expansion model (S-box derived from
// GF(2^8) inversion + affine map), plus a NUM_ROUNDS=3 instance.
module tb_aes_key_schedule;

  typedef struct packed {
    logic [127:0] rk;
    logic [3:0]   rnd;
  } exp_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
  localparam logic [127:0] FIPS_R1  = 128'ha088232a_fa54a36c_fe2c3976_17b13905;
  localparam logic [127:0] FIPS_R10 = 128'hd0c9e1b6_14ee3f63_f9250c0c_a889c8a6;
  localparam logic [127:0] ZERO_R1  = 128'h62626262_63636363_63636363_63636363;
  localparam logic [127:0] ALT_KEY  = 128'h0004080c_0105090d_02060a0e_03070b0f;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_schedule_if ifc ();
  aes_key_schedule_if ifc3 ();

  aes_key_schedule #(.NUM_ROUNDS(10)) dut (.clk(clk), .rst_n(rst_n), .ks(ifc));
  aes_key_schedule #(.NUM_ROUNDS(3))  dut3 (.clk(clk), .rst_n(rst_n), .ks(ifc3));

  int errors = 0;
  int checks = 0;

  exp_t         sb_q[$];
  logic [7:0]   tb_sbox [256];
  logic [127:0] model_rk [11];
  logic [127:0] obs_rk [16];
  logic [7:0]   rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, rot, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      s = inv; rot = inv;
      for (int k = 0; k < 4; k++) begin
        rot = {rot[6:0], rot[7]};
        s = s ^ rot;
      end
      tb_sbox[x] = s ^ 8'h63;
    end
  endtask

  // Standard w[0..43] expansion on column words, then repacked row-major.
  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    for (int c = 0; c < 4; c++)
      w[c] = {key[127-8*c -: 8], key[95-8*c -: 8], key[63-8*c -: 8], key[31-8*c -: 8]};
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {tb_sbox[tmp[31:24]], tb_sbox[tmp[23:16]], tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]]};
        tmp = tmp ^ {rcon_tbl[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 11; k++)
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          model_rk[k][127-32*r-8*c -: 8] = w[4*k+c][31-8*r -: 8];
  endtask

  // Waits for key_ready, loads the key, pushes the expected stream and
  // checks round key 0 appears the cycle after acceptance.
  task automatic start_key(input logic [127:0] k);
    int waitc = 0;
    while (ifc.key_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (ifc.key_ready !== 1'b1) begin
      errors++;
      $display("FAIL key_ready_wait: key_ready=%b required 1 within 50 cycles", ifc.key_ready);
    end
    compute_model(k);
    for (int r = 0; r < 11; r++) sb_q.push_back('{rk: model_rk[r], rnd: 4'(r)});
    ifc.key_in = k;
    ifc.key_valid = 1'b1;
    @(negedge clk);
    ifc.key_valid = 1'b0;
    checks++;
    if (ifc.rk_valid !== 1'b1 || ifc.rk_round !== 4'd0 || ifc.rk_out !== k) begin
      errors++;
      $display("FAIL first_key: valid=%b round=%0d rk=%h required valid=1 round=0 rk=%h",
               ifc.rk_valid, ifc.rk_round, ifc.rk_out, k);
    end
  endtask

  // mode 0: rk_ready held high, 1: random. Stops when scoreboard is empty,
  // after stop_after transfers (if >0), or on cycle budget.
  task automatic drain(input int mode, input int stop_after, input int inject_at,
                       input logic [127:0] inject_key, output int n_xfer);
    logic [127:0] prev_rk;
    logic         prev_stall;
    exp_t         e;
    int           cyc;
    n_xfer = 0; prev_stall = 1'b0; prev_rk = '0; cyc = 0;
    while (sb_q.size() > 0 && cyc < 300 && !(stop_after > 0 && n_xfer >= stop_after)) begin
      ifc.rk_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (cyc == inject_at) begin
        ifc.key_in = inject_key;
        ifc.key_valid = 1'b1;
        checks++;
        if (ifc.key_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_key_ready: key_ready=%b required 0", ifc.key_ready);
        end
      end else begin
        ifc.key_valid = 1'b0;
      end
      if (prev_stall) begin
        checks++;
        if (ifc.rk_out !== prev_rk) begin
          errors++;
          $display("FAIL stall_stable: rk=%h required %h", ifc.rk_out, prev_rk);
        end
      end
      if (ifc.rk_valid && ifc.rk_ready) begin
        e = sb_q.pop_front();
        $display("xfer round=%0d rk=%h rcon=%h", ifc.rk_round, ifc.rk_out, dut.rcon_q);
        checks++;
        if (ifc.rk_out !== e.rk || ifc.rk_round !== e.rnd) begin
          errors++;
          $display("FAIL round_key: round=%0d rk=%h required round=%0d rk=%h",
                   ifc.rk_round, ifc.rk_out, e.rnd, e.rk);
        end
        if (e.rnd < 4'd10) begin
          checks++;
          if (dut.rcon_q !== rcon_tbl[e.rnd]) begin
            errors++;
            $display("FAIL rcon: round=%0d rcon=%h required %h", e.rnd, dut.rcon_q, rcon_tbl[e.rnd]);
          end
        end
        obs_rk[e.rnd] = ifc.rk_out;
        n_xfer++;
        prev_stall = 1'b0;
      end else begin
        checks++;
        if (ifc.rk_valid !== 1'b1) begin
          errors++;
          $display("FAIL valid_held: rk_valid=%b required 1", ifc.rk_valid);
        end
        prev_stall = 1'b1;
        prev_rk = ifc.rk_out;
      end
      cyc++;
      @(negedge clk);
    end
    ifc.key_valid = 1'b0;
    ifc.rk_ready = 1'b0;
    if (cyc >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d keys outstanding required 0", sb_q.size());
    end
  endtask

  task automatic check_idle_after(input string name);
    checks++;
    if (ifc.key_ready !== 1'b1 || ifc.rk_valid !== 1'b0 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: key_ready=%b rk_valid=%b busy=%b required 1 0 0",
               name, ifc.key_ready, ifc.rk_valid, ifc.busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (ifc.key_ready !== 1'b1 || ifc.rk_valid !== 1'b0 || ifc.busy !== 1'b0 ||
        ifc.rk_out !== 128'h0 || ifc.rk_round !== 4'd0 || dut.rcon_q !== 8'h01) begin
      errors++;
      $display("FAIL reset_state: kr=%b v=%b busy=%b rk=%h round=%0d rcon=%h required 1 0 0 0 0 01",
               ifc.key_ready, ifc.rk_valid, ifc.busy, ifc.rk_out, ifc.rk_round, dut.rcon_q);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_after("idle_after_reset");
    $display("reset done");
  endtask

  task automatic test_fips();
    int n;
    start_key(FIPS_KEY);
    drain(0, 0, -1, '0, n);
    check_idle_after("fips_end_idle");
    checks++;
    if (n != 11 || obs_rk[1] !== FIPS_R1 || obs_rk[10] !== FIPS_R10) begin
      errors++;
      $display("FAIL fips_vectors: n=%0d r1=%h r10=%h required 11 %h %h",
               n, obs_rk[1], obs_rk[10], FIPS_R1, FIPS_R10);
    end
  endtask

  task automatic test_stall();
    int n;
    obs_rk[1] = '0; obs_rk[10] = '0;
    start_key(FIPS_KEY);
    drain(1, 0, -1, '0, n);
    check_idle_after("stall_end_idle");
    checks++;
    if (n != 11 || obs_rk[1] !== FIPS_R1 || obs_rk[10] !== FIPS_R10) begin
      errors++;
      $display("FAIL stall_vectors: n=%0d r1=%h r10=%h required 11 %h %h",
               n, obs_rk[1], obs_rk[10], FIPS_R1, FIPS_R10);
    end
  endtask

  task automatic test_ignore_busy_key();
    int n;
    start_key(FIPS_KEY);
    drain(0, 0, 3, ALT_KEY, n);
    check_idle_after("ignore_end_idle");
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL ignore_count: transfers=%0d required 11", n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    start_key(FIPS_KEY);
    drain(0, 5, -1, '0, n);
    rst_n = 1'b0;
    #1;
    checks++;
    if (n != 5 || ifc.rk_valid !== 1'b0 || ifc.key_ready !== 1'b1 ||
        ifc.rk_round !== 4'd0 || ifc.rk_out !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset: n=%0d v=%b kr=%b round=%0d rk=%h required 5 0 1 0 0",
               n, ifc.rk_valid, ifc.key_ready, ifc.rk_round, ifc.rk_out);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_key(ALT_KEY);
    drain(0, 0, -1, '0, n);
    check_idle_after("after_reset_end_idle");
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL after_reset_count: transfers=%0d required 11", n);
    end
  endtask

  task automatic test_zero_key();
    int n;
    start_key(128'h0);
    drain(1, 0, -1, '0, n);
    checks++;
    if (n != 11 || obs_rk[1] !== ZERO_R1) begin
      errors++;
      $display("FAIL zero_key_r1: n=%0d r1=%h required 11 %h", n, obs_rk[1], ZERO_R1);
    end
  endtask

  task automatic test_short_build();
    int cnt = 0;
    int cyc = 0;
    exp_t e;
    compute_model(FIPS_KEY);
    for (int r = 0; r < 4; r++) sb_q.push_back('{rk: model_rk[r], rnd: 4'(r)});
    ifc3.key_in = FIPS_KEY;
    ifc3.key_valid = 1'b1;
    ifc3.rk_ready = 1'b1;
    @(negedge clk);
    ifc3.key_valid = 1'b0;
    while (cyc < 20) begin
      if (ifc3.rk_valid === 1'b1) begin
        $display("xfer3 round=%0d rk=%h", ifc3.rk_round, ifc3.rk_out);
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL short_extra: round=%0d required no transfer", ifc3.rk_round);
        end else begin
          e = sb_q.pop_front();
          if (ifc3.rk_out !== e.rk || ifc3.rk_round !== e.rnd) begin
            errors++;
            $display("FAIL short_key: round=%0d rk=%h required round=%0d rk=%h",
                     ifc3.rk_round, ifc3.rk_out, e.rnd, e.rk);
          end
        end
        cnt++;
      end else if (cnt > 0) begin
        break;
      end
      cyc++;
      @(negedge clk);
    end
    ifc3.rk_ready = 1'b0;
    checks++;
    if (cnt != 4 || ifc3.key_ready !== 1'b1 || ifc3.rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_count: transfers=%0d key_ready=%b rk_valid=%b required 4 1 0",
               cnt, ifc3.key_ready, ifc3.rk_valid);
    end
    sb_q.delete();
  endtask

  initial begin
    ifc.key_in = '0;  ifc.key_valid = 1'b0;  ifc.rk_ready = 1'b0;
    ifc3.key_in = '0; ifc3.key_valid = 1'b0; ifc3.rk_ready = 1'b0;
    build_sbox();
    test_reset();
    test_fips();
    test_stall();
    test_ignore_busy_key();
    test_reset_mid();
    test_zero_key();
    test_short_build();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
